// File: rtl/pn2112_pkg.sv
// Shared constants and FSM state type for the PN2112 block generator.
package pn2112_pkg;

  localparam int PN_LEN = 2112;
  localparam int LFSR_W = 58;
  localparam int TAP_A  = 57;
  localparam int TAP_B  = 38;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 58'h2aaaaaaaaaaaaaa;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/pn2112_advance.sv
// Combinational WIDTH-step advance of the 58-bit PN register, emitting the
// produced stream bits LSB-first (bits[0] is the earliest bit).
module pn2112_advance
  import pn2112_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [LFSR_W-1:0] r_in,
  output logic [WIDTH-1:0]  bits,
  output logic [LFSR_W-1:0] r_out
);

  logic [LFSR_W-1:0] lfsr_s;
  logic              fb;

  always_comb begin
    lfsr_s = r_in;
    bits   = '0;
    fb     = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      fb      = lfsr_s[TAP_A] ^ lfsr_s[TAP_B];
      bits[i] = fb;
      lfsr_s  = {lfsr_s[LFSR_W-2:0], fb};
    end
    r_out = lfsr_s;
  end

endmodule

// File: rtl/pn2112_gen.sv
// PN2112 block generator: emits 2112-bit PN blocks as WIDTH-bit words with a
// valid/ready handshake, start/stop/restart control and a loadable seed.
module pn2112_gen
  import pn2112_pkg::*;
#(
  parameter int                WIDTH = 32,
  parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              start,
  input  logic              stop,
  input  logic              restart,
  input  logic              cont,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              ready,
  output logic [WIDTH-1:0]  dout,
  output logic              valid,
  output logic              sop,
  output logic              eop,
  output logic [6:0]        word_idx
);

  localparam int         WORDS    = PN_LEN / WIDTH;
  localparam logic [6:0] LAST_IDX = 7'(WORDS - 1);

  generate
    if (!(WIDTH == 32 || WIDTH == 64 || WIDTH == 66 || WIDTH == 132)) begin : g_bad_width
      $error("pn2112_gen: WIDTH must be 32, 64, 66 or 132");
    end
  endgenerate

  state_t            state_reg;
  logic [LFSR_W-1:0] seed_reg;
  logic [LFSR_W-1:0] r_reg;
  logic [WIDTH-1:0]  dout_reg;
  logic              valid_reg;
  logic              sop_reg;
  logic              eop_reg;
  logic [6:0]        word_idx_reg;

  logic              in_run;
  logic              fresh_block;
  logic              reseed;
  logic              step_word;
  logic [6:0]        idx_next;
  logic [LFSR_W-1:0] load_seed;
  logic [LFSR_W-1:0] adv_in;
  logic [WIDTH-1:0]  adv_bits;
  logic [LFSR_W-1:0] adv_r;

  // A same-cycle seed_load bypasses the seed register so the reload sees it.
  always_comb begin
    in_run      = (state_reg == RUN) && !stop;
    load_seed   = seed_load ? seed_in : seed_reg;
    fresh_block = 1'b0;
    reseed      = 1'b0;
    step_word   = 1'b0;
    if (state_reg == IDLE && start) begin
      fresh_block = 1'b1;
      reseed      = 1'b1;
      step_word   = 1'b1;
    end else if (in_run && restart) begin
      fresh_block = 1'b1;
      reseed      = 1'b1;
      step_word   = 1'b1;
    end else if (in_run && ready) begin
      step_word   = 1'b1;
      fresh_block = eop_reg;
      reseed      = eop_reg && !cont;
    end
    idx_next = fresh_block ? 7'd0 : word_idx_reg + 7'd1;
    adv_in   = reseed ? load_seed : r_reg;
  end

  pn2112_advance #(.WIDTH(WIDTH)) u_advance (
    .r_in  (adv_in),
    .bits  (adv_bits),
    .r_out (adv_r)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg    <= IDLE;
      seed_reg     <= SEED;
      r_reg        <= SEED;
      dout_reg     <= '0;
      valid_reg    <= 1'b0;
      sop_reg      <= 1'b0;
      eop_reg      <= 1'b0;
      word_idx_reg <= 7'd0;
    end else begin
      if (seed_load) begin
        seed_reg <= seed_in;
      end
      if (state_reg == RUN && stop) begin
        state_reg    <= IDLE;
        valid_reg    <= 1'b0;
        sop_reg      <= 1'b0;
        eop_reg      <= 1'b0;
        word_idx_reg <= 7'd0;
      end else if (step_word) begin
        // r_reg always holds the register state just past the word on dout.
        state_reg    <= RUN;
        dout_reg     <= adv_bits;
        r_reg        <= adv_r;
        valid_reg    <= 1'b1;
        sop_reg      <= fresh_block;
        eop_reg      <= (idx_next == LAST_IDX);
        word_idx_reg <= idx_next;
      end
    end
  end

  assign dout     = dout_reg;
  assign valid    = valid_reg;
  assign sop      = sop_reg;
  assign eop      = eop_reg;
  assign word_idx = word_idx_reg;

endmodule

// File: tb/tb_pn2112_gen.sv
// Self-checking bench for pn2112_gen at WIDTH=32 and WIDTH=64 against a
// recurrence-based stream model x[n] = x[n-58] ^ x[n-39].
module tb_pn2112_gen;

  localparam logic [57:0] DEF_SEED = 58'h2aaaaaaaaaaaaaa;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        start = 1'b0, stop = 1'b0, restart = 1'b0, cont = 1'b0;
  logic        seed_load = 1'b0, ready = 1'b0;
  logic [57:0] seed_in = '0;

  logic [31:0] dout32;
  logic        valid32, sop32, eop32;
  logic [6:0]  idx32;
  logic [63:0] dout64;
  logic        valid64, sop64, eop64;
  logic [6:0]  idx64;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4223:0] s_def;
  logic [4223:0] s_one;

  always #5 clk = ~clk;

  pn2112_gen #(.WIDTH(32)) d32 (
    .clk(clk), .arst(arst), .start(start), .stop(stop), .restart(restart),
    .cont(cont), .seed_load(seed_load), .seed_in(seed_in), .ready(ready),
    .dout(dout32), .valid(valid32), .sop(sop32), .eop(eop32), .word_idx(idx32)
  );

  pn2112_gen #(.WIDTH(64)) d64 (
    .clk(clk), .arst(arst), .start(start), .stop(stop), .restart(restart),
    .cont(cont), .seed_load(seed_load), .seed_in(seed_in), .ready(ready),
    .dout(dout64), .valid(valid64), .sop(sop64), .eop(eop64), .word_idx(idx64)
  );

  // Stream bit n depends on the bits 58 and 39 positions earlier; the seed
  // supplies the 58 bits of pre-history (seed[i] is bit -1-i).
  task automatic make_stream(input logic [57:0] seed, output logic [4223:0] s);
    logic h [0:4281];
    for (int i = 0; i < 58; i++) h[i] = seed[57-i];
    for (int j = 58; j < 4282; j++) h[j] = h[j-58] ^ h[j-39];
    for (int n = 0; n < 4224; n++) s[n] = h[n+58];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; stop = 0; restart = 0; cont = 0; seed_load = 0; seed_in = '0; ready = 0;
    arst = 1;
    step();
    arst = 0;
    step();
  endtask

  task automatic test_reset();
    #2 arst = 1;
    #1;
    n_tests++;
    if (dout32 !== 32'h0 || valid32 !== 1'b0 || sop32 !== 1'b0 || eop32 !== 1'b0 || idx32 !== 7'd0) begin
      n_fail++;
      $display("FAIL reset32: dout=%h valid=%b sop=%b eop=%b idx=%0d, expected all zero", dout32, valid32, sop32, eop32, idx32);
    end
    n_tests++;
    if (dout64 !== 64'h0 || valid64 !== 1'b0 || sop64 !== 1'b0 || eop64 !== 1'b0 || idx64 !== 7'd0) begin
      n_fail++;
      $display("FAIL reset64: dout=%h valid=%b sop=%b eop=%b idx=%0d, expected all zero", dout64, valid64, sop64, eop64, idx64);
    end
    step();
    arst = 0;
    ready = 1; stop = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if (valid32 !== 1'b0 || sop32 !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset: valid=%b sop=%b, expected 0 0", valid32, sop32);
      end
    end
    stop = 0; ready = 0;
    $display("[TB] reset checks done");
  endtask

  task automatic test_basic();
    logic [63:0] blk1 [0:32];
    do_reset();
    start = 1; ready = 1;
    step();
    start = 0;
    for (int c = 0; c < 132; c++) begin
      int k32;
      int k64;
      k32 = c % 66;
      k64 = c % 33;
      n_tests++;
      if (dout32 !== s_def[k32*32 +: 32] || valid32 !== 1'b1 || sop32 !== (k32 == 0) ||
          eop32 !== (k32 == 65) || idx32 !== 7'(k32)) begin
        n_fail++;
        $display("FAIL basic32 word %0d: dout=%h sop=%b eop=%b idx=%0d valid=%b, expected dout=%h sop=%b eop=%b idx=%0d",
                 c, dout32, sop32, eop32, idx32, valid32, s_def[k32*32 +: 32], (k32 == 0), (k32 == 65), k32);
      end else begin
        $display("[TB] basic32 word %0d dout=%h", c, dout32);
      end
      n_tests++;
      if (dout64 !== s_def[k64*64 +: 64] || valid64 !== 1'b1 || sop64 !== (k64 == 0) ||
          eop64 !== (k64 == 32) || idx64 !== 7'(k64)) begin
        n_fail++;
        $display("FAIL basic64 word %0d: dout=%h sop=%b eop=%b idx=%0d, expected dout=%h sop=%b eop=%b idx=%0d",
                 c, dout64, sop64, eop64, idx64, s_def[k64*64 +: 64], (k64 == 0), (k64 == 32), k64);
      end
      if (c == 0) begin
        n_tests++;
        if (dout32 !== 32'hffffffff) begin
          n_fail++;
          $display("FAIL word0_32: dout=%h, expected ffffffff", dout32);
        end
        n_tests++;
        if (dout64 !== 64'h02aaaaff_ffffffff) begin
          n_fail++;
          $display("FAIL word0_64: dout=%h, expected 02aaaaffffffffff", dout64);
        end
      end
      if (c == 1) begin
        n_tests++;
        if (dout32 !== 32'h02aaaaff) begin
          n_fail++;
          $display("FAIL word1_32: dout=%h, expected 02aaaaff", dout32);
        end
      end
      if (c < 33) begin
        blk1[c] = dout64;
      end else if (c < 66) begin
        n_tests++;
        if (dout64 !== blk1[c-33]) begin
          n_fail++;
          $display("FAIL block_repeat64 word %0d: dout=%h, expected %h", c - 33, dout64, blk1[c-33]);
        end
      end
      step();
    end
    ready = 0;
  endtask

  task automatic test_cont();
    do_reset();
    cont = 1; start = 1; ready = 1;
    step();
    start = 0;
    for (int c = 0; c < 132; c++) begin
      n_tests++;
      if (dout32 !== s_def[c*32 +: 32] || sop32 !== (c % 66 == 0) || idx32 !== 7'(c % 66)) begin
        n_fail++;
        $display("FAIL cont32 word %0d: dout=%h sop=%b idx=%0d, expected dout=%h sop=%b idx=%0d",
                 c, dout32, sop32, idx32, s_def[c*32 +: 32], (c % 66 == 0), c % 66);
      end else begin
        $display("[TB] cont32 word %0d dout=%h", c, dout32);
      end
      if (c == 66) begin
        n_tests++;
        if (dout32 === 32'hffffffff) begin
          n_fail++;
          $display("FAIL cont_block2_word0: dout=%h, expected not ffffffff", dout32);
        end
      end
      step();
    end
    ready = 0; cont = 0;
  endtask

  task automatic test_random_ready();
    int          k;
    logic [31:0] p_dout;
    logic        p_sop, p_eop, p_ready;
    logic [6:0]  p_idx;
    do_reset();
    start = 1; ready = 0;
    step();
    start = 0;
    k = 0; p_ready = 1'b1;
    p_dout = '0; p_sop = 0; p_eop = 0; p_idx = '0;
    for (int c = 0; c < 400; c++) begin
      n_tests++;
      if (dout32 !== s_def[(k % 66)*32 +: 32] || valid32 !== 1'b1 || idx32 !== 7'(k % 66) ||
          sop32 !== (k % 66 == 0) || eop32 !== (k % 66 == 65)) begin
        n_fail++;
        $display("FAIL rand_ready hs %0d: dout=%h idx=%0d sop=%b eop=%b, expected dout=%h idx=%0d",
                 k, dout32, idx32, sop32, eop32, s_def[(k % 66)*32 +: 32], k % 66);
      end
      if (!p_ready) begin
        n_tests++;
        if (dout32 !== p_dout || sop32 !== p_sop || eop32 !== p_eop || idx32 !== p_idx) begin
          n_fail++;
          $display("FAIL stall_stable cycle %0d: dout=%h idx=%0d, expected held dout=%h idx=%0d",
                   c, dout32, idx32, p_dout, p_idx);
        end
      end
      ready   = 1'($urandom % 2);
      p_ready = ready;
      p_dout  = dout32; p_sop = sop32; p_eop = eop32; p_idx = idx32;
      if (ready) $display("[TB] rand_ready handshake %0d dout=%h", k, dout32);
      step();
      if (p_ready) k++;
    end
    ready = 0;
  endtask

  task automatic test_restart();
    do_reset();
    start = 1; ready = 1;
    step();
    start = 0;
    for (int c = 0; c < 10; c++) step();
    n_tests++;
    if (idx32 !== 7'd10 || dout32 !== s_def[10*32 +: 32]) begin
      n_fail++;
      $display("FAIL pre_restart: idx=%0d dout=%h, expected idx=10 dout=%h", idx32, dout32, s_def[10*32 +: 32]);
    end
    restart = 1; ready = 0;
    step();
    restart = 0;
    n_tests++;
    if (dout32 !== 32'hffffffff || sop32 !== 1'b1 || idx32 !== 7'd0 || valid32 !== 1'b1) begin
      n_fail++;
      $display("FAIL restart: dout=%h sop=%b idx=%0d valid=%b, expected ffffffff 1 0 1", dout32, sop32, idx32, valid32);
    end
    ready = 1;
    for (int c = 0; c < 5; c++) step();
    n_tests++;
    if (idx32 !== 7'd5 || dout32 !== s_def[5*32 +: 32]) begin
      n_fail++;
      $display("FAIL post_restart_word5: idx=%0d dout=%h, expected idx=5 dout=%h", idx32, dout32, s_def[5*32 +: 32]);
    end
    stop = 1; restart = 1;
    step();
    stop = 0; restart = 0;
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (valid32 !== 1'b0 || sop32 !== 1'b0 || eop32 !== 1'b0) begin
        n_fail++;
        $display("FAIL stop_wins: valid=%b sop=%b eop=%b, expected 0 0 0", valid32, sop32, eop32);
      end
      step();
    end
    start = 1;
    step();
    start = 0;
    n_tests++;
    if (dout32 !== 32'hffffffff || sop32 !== 1'b1 || valid32 !== 1'b1) begin
      n_fail++;
      $display("FAIL start_after_stop: dout=%h sop=%b valid=%b, expected ffffffff 1 1", dout32, sop32, valid32);
    end
    $display("[TB] restart/stop checks done");
    ready = 0;
  endtask

  task automatic test_seed_load();
    do_reset();
    start = 1; ready = 1;
    step();
    start = 0;
    for (int c = 0; c < 106; c++) begin
      logic [31:0] exp_w;
      exp_w = (c < 66) ? s_def[c*32 +: 32] : s_one[(c-66)*32 +: 32];
      n_tests++;
      if (dout32 !== exp_w || sop32 !== (c % 66 == 0)) begin
        n_fail++;
        $display("FAIL seed_load word %0d: dout=%h sop=%b, expected dout=%h sop=%b", c, dout32, sop32, exp_w, (c % 66 == 0));
      end else begin
        $display("[TB] seed_load word %0d dout=%h", c, dout32);
      end
      if (c == 20) begin
        seed_load = 1; seed_in = 58'h1;
      end
      step();
      seed_load = 0;
    end
    arst = 1;
    #1;
    n_tests++;
    if (dout32 !== 32'h0 || valid32 !== 1'b0 || sop32 !== 1'b0 || eop32 !== 1'b0 || idx32 !== 7'd0) begin
      n_fail++;
      $display("FAIL arst_midblock: dout=%h valid=%b sop=%b eop=%b idx=%0d, expected all zero",
               dout32, valid32, sop32, eop32, idx32);
    end
    step();
    arst = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if (valid32 !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_after_arst: valid=%b, expected 0", valid32);
      end
    end
    start = 1;
    step();
    start = 0;
    n_tests++;
    if (dout32 !== 32'hffffffff) begin
      n_fail++;
      $display("FAIL seed_after_arst: dout=%h, expected ffffffff", dout32);
    end
    ready = 0;
  endtask

  task automatic test_zero_seed();
    do_reset();
    seed_in = '0; seed_load = 1; start = 1; ready = 1;
    step();
    seed_load = 0; start = 0;
    for (int c = 0; c < 6; c++) begin
      n_tests++;
      if (dout32 !== 32'h0 || dout64 !== 64'h0 || valid32 !== 1'b1) begin
        n_fail++;
        $display("FAIL zero_seed word %0d: dout32=%h dout64=%h valid=%b, expected 0 0 1", c, dout32, dout64, valid32);
      end else begin
        $display("[TB] zero_seed word %0d dout=%h", c, dout32);
      end
      step();
    end
    ready = 0;
  endtask

  initial begin
    make_stream(DEF_SEED, s_def);
    make_stream(58'h1, s_one);
    test_reset();
    test_basic();
    test_cont();
    test_random_ready();
    test_restart();
    test_seed_load();
    test_zero_seed();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
